// File: rtl/generation_sequencer_if.sv
// Configuration handshake from the link-control register file into one generation sequencer.
interface generation_sequencer_if #(
    parameter int RATE_W = 16
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [RATE_W-1:0] half_rate;
    logic              polarity;
    logic [RATE_W-1:0] sync_offset;

    modport master (
        output cfg_valid, half_rate, polarity, sync_offset,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, half_rate, polarity, sync_offset,
        output cfg_ready
    );
endinterface

// File: rtl/generation_sequencer.sv
// Sequences stop -> drain -> load -> start for one generation instance and derives its compare values.
// Optional drain watchdog (ERR state) is built when CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN is defined.
module generation_sequencer #(
    parameter int RATE_W        = 16,
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
    parameter int DRAIN_TIMEOUT = 1024,
`endif
    parameter int ANTICIPATION  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    generation_sequencer_if.slave cfg_if,
    input  logic                  run_req_i,
    input  logic                  pause_req_i,
    input  logic                  gen_busy_i,
    output logic                  gen_en_o,
    output logic                  set_polarity_o,
    output logic                  starting_polarity_o,
    output logic [RATE_W-1:0]     exp_half_m2_o,
    output logic [RATE_W-1:0]     exp_qtr_m1_o,
    output logic [RATE_W-1:0]     pre_half_m1_o,
    output logic [RATE_W-1:0]     pre_qtr_m1_o,
    output logic [RATE_W-1:0]     sync_offset_o,
    output logic                  pause_en_o,
    output logic                  pause_polarity_o,
    output logic [2:0]            state_o,
    output logic                  cfg_error_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRIME = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [RATE_W:0]   LEGAL_MIN = (RATE_W+1)'(2*ANTICIPATION + 2);
    localparam logic [RATE_W-1:0] ANT       = RATE_W'(ANTICIPATION);

    function automatic logic is_legal(input logic [RATE_W-1:0] h);
        return {1'b0, h} >= LEGAL_MIN;
    endfunction

    function automatic logic [RATE_W-1:0] half_m1(input logic [RATE_W-1:0] h);
        return (h >> 1) - RATE_W'(1);
    endfunction

    state_t            state_q;
    logic              live_q;
    logic              have_cfg_q;
    logic [RATE_W-1:0] h_q;
    logic              pol_q;
    logic [RATE_W-1:0] off_q;
    logic              gen_en_q;
    logic              set_pol_q;
    logic              start_pol_q;
    logic [RATE_W-1:0] exp_half_q;
    logic [RATE_W-1:0] exp_qtr_q;
    logic [RATE_W-1:0] pre_half_q;
    logic [RATE_W-1:0] pre_qtr_q;
    logic [RATE_W-1:0] sync_off_q;
    logic              pause_en_q;
    logic              pause_pol_q;
    logic              cfg_error_q;
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
    logic [$clog2(DRAIN_TIMEOUT+1)-1:0] drain_cnt_q;
`endif

    logic cfg_ready;
    logic cfg_accept;
    logic cfg_legal;

    // Ready is withheld while the clock is gated so a handshake never completes without being captured.
    assign cfg_ready  = live_q && clk_en &&
                        ((state_q == IDLE) || (state_q == DRAIN && !gen_busy_i));
    assign cfg_accept = cfg_if.cfg_valid && cfg_ready;
    assign cfg_legal  = is_legal(cfg_if.half_rate);
    assign cfg_if.cfg_ready = cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            live_q      <= 1'b0;
            have_cfg_q  <= 1'b0;
            h_q         <= '0;
            pol_q       <= 1'b0;
            off_q       <= '0;
            gen_en_q    <= 1'b0;
            set_pol_q   <= 1'b0;
            start_pol_q <= 1'b0;
            exp_half_q  <= '0;
            exp_qtr_q   <= '0;
            pre_half_q  <= '0;
            pre_qtr_q   <= '0;
            sync_off_q  <= '0;
            pause_en_q  <= 1'b0;
            pause_pol_q <= 1'b0;
            cfg_error_q <= 1'b0;
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
            drain_cnt_q <= '0;
`endif
        end else begin
            live_q <= 1'b1;
            if (clk_en) begin
                set_pol_q <= 1'b0;
                if (cfg_accept) begin
                    if (cfg_legal) begin
                        h_q         <= cfg_if.half_rate;
                        pol_q       <= cfg_if.polarity;
                        off_q       <= cfg_if.sync_offset;
                        have_cfg_q  <= 1'b1;
                        cfg_error_q <= 1'b0;
                    end else begin
                        cfg_error_q <= 1'b1;
                    end
                end
                case (state_q)
                    IDLE: begin
                        gen_en_q   <= 1'b0;
                        pause_en_q <= 1'b0;
                        if (run_req_i && (have_cfg_q || (cfg_accept && cfg_legal)))
                            state_q <= LOAD;
                    end
                    LOAD: begin
                        exp_half_q  <= h_q - RATE_W'(2);
                        exp_qtr_q   <= half_m1(h_q);
                        pre_half_q  <= h_q - RATE_W'(1) - ANT;
                        pre_qtr_q   <= half_m1(h_q) - ANT;
                        start_pol_q <= pol_q;
                        sync_off_q  <= off_q;
                        set_pol_q   <= 1'b1;
                        state_q     <= PRIME;
                    end
                    PRIME: begin
                        gen_en_q <= 1'b1;
                        state_q  <= RUN;
                    end
                    RUN: begin
                        if (cfg_if.cfg_valid || !run_req_i) begin
                            gen_en_q   <= 1'b0;
                            pause_en_q <= 1'b0;
                            state_q    <= DRAIN;
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
                            drain_cnt_q <= '0;
`endif
                        end else begin
                            pause_en_q  <= pause_req_i;
                            pause_pol_q <= cfg_if.polarity;
                        end
                    end
                    DRAIN: begin
                        // run_req_i is only looked at once the generator has gone quiet.
                        if (!gen_busy_i) begin
                            state_q <= (cfg_if.cfg_valid && run_req_i) ? LOAD : IDLE;
                        end
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
                        else if (32'(drain_cnt_q) == DRAIN_TIMEOUT - 1) begin
                            state_q     <= ERR;
                            cfg_error_q <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
`endif
                    end
`ifdef CLKS_ALOT_SEQ_DRAIN_TIMEOUT_EN
                    ERR: begin
                        gen_en_q    <= 1'b0;
                        cfg_error_q <= 1'b1;
                        if (!run_req_i)
                            state_q <= IDLE;
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gen_en_o            = gen_en_q;
    assign set_polarity_o      = set_pol_q;
    assign starting_polarity_o = start_pol_q;
    assign exp_half_m2_o       = exp_half_q;
    assign exp_qtr_m1_o        = exp_qtr_q;
    assign pre_half_m1_o       = pre_half_q;
    assign pre_qtr_m1_o        = pre_qtr_q;
    assign sync_offset_o       = sync_off_q;
    assign pause_en_o          = pause_en_q;
    assign pause_polarity_o    = pause_pol_q;
    assign state_o             = state_q;
    assign cfg_error_o         = cfg_error_q;

endmodule
